// File: rtl/seg_pkg.sv
// seg_pkg: shared encodings for the seg_scan_3 display stage.
// Converter FSM states, seven-segment digit patterns (active-low,
// {dp,g,f,e,d,c,b,a}) and the active-low one-hot digit enables.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [2:0] AN_ONES = 3'b110;
    localparam logic [2:0] AN_TENS = 3'b101;
    localparam logic [2:0] AN_HUND = 3'b011;
    localparam logic [2:0] AN_OFF  = 3'b111;

    // Digit code to segment pattern; codes above 9 go dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 8-bit binary to
// three BCD digits. Re-runs whenever the input differs from the last
// captured value; input changes mid-conversion are ignored.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in,
    output logic [11:0] bcd,
    output logic        done
);

    state_t      r_state, w_next;
    logic [7:0]  r_last;
    logic [7:0]  r_shreg;
    logic [11:0] r_scratch;
    logic [2:0]  r_cnt;
    logic [11:0] r_bcd;
    logic        r_done;
    logic [11:0] w_adj;
    logic        w_load, w_shift, w_finish;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state: 8 shifts, then one DONE cycle back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in != r_last) w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == 3'd7) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs steering the datapath.
    always_comb begin
        w_load   = (r_state == ST_IDLE) && (in != r_last);
        w_shift  = (r_state == ST_SHIFT);
        w_finish = (r_state == ST_DONE);
    end

    // Add-3 correction on every scratch nibble that is 5 or more.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Datapath: capture, shift {scratch, shreg} left, publish result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last    <= 8'd0;
            r_shreg   <= 8'd0;
            r_scratch <= 12'd0;
            r_cnt     <= 3'd0;
            r_bcd     <= 12'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_shreg   <= in;
                r_last    <= in;
                r_scratch <= 12'd0;
                r_cnt     <= 3'd0;
            end
            if (w_shift) begin
                r_scratch <= {w_adj[10:0], r_shreg[7]};
                r_shreg   <= {r_shreg[6:0], 1'b0};
                r_cnt     <= r_cnt + 3'd1;
            end
            if (w_finish) r_bcd <= r_scratch;
        end
    end

    assign bcd  = r_bcd;
    assign done = r_done;

endmodule

// File: rtl/seg_scan_3.sv
// seg_scan_3: 3-digit multiplexed common-anode seven-segment driver fed
// by a sequential binary-to-BCD converter. The scan free-runs.
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_3
    import seg_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in,
    output logic [11:0] bcd,
    output logic        done,
    output logic [2:0]  an,
    output logic [7:0]  seg
);

    logic [15:0] r_pre;
    logic [1:0]  r_idx;
    logic [2:0]  r_an;
    logic [7:0]  r_seg;
    logic        w_wrap;
    logic [3:0]  w_digit;
    logic [2:0]  w_an;
    logic        w_blank;
    logic [11:0] w_bcd;

    bin2bcd_seq u_conv (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .bcd  (w_bcd),
        .done (done)
    );

    assign w_wrap = (r_pre == SCAN_DIV - 16'd1);

    // Prescaler and digit index: index steps 0->1->2->0 on each wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= 16'd0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_pre <= 16'd0;
            r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    // Select the digit and its enable for the current index.
    always_comb begin
        w_an    = AN_OFF;
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_idx)
            2'd0: begin w_an = AN_ONES; w_digit = w_bcd[3:0];  end
            2'd1: begin w_an = AN_TENS; w_digit = w_bcd[7:4];  end
            2'd2: begin w_an = AN_HUND; w_digit = w_bcd[11:8]; end
            default: w_blank = 1'b1;
        endcase
`ifdef SEG_SCAN_LZB_EN
        if (r_idx == 2'd2 && w_bcd[11:8] == 4'd0)
            w_blank = 1'b1;
        if (r_idx == 2'd1 && w_bcd[11:8] == 4'd0 && w_bcd[7:4] == 4'd0)
            w_blank = 1'b1;
`endif
    end

    // Output register: enables and pattern move together each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_blank ? SEG_BLANK : seg_decode(w_digit);
        end
    end

    assign bcd = w_bcd;
    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan_3.sv
// tb_seg_scan_3: directed + randomized self-checking bench for seg_scan_3
// with SCAN_DIV=4. Expected values come from decimal arithmetic on the
// input value and the digit pattern table.
module tb_seg_scan_3;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in  = 8'd0;
    logic [11:0] bcd;
    logic        done;
    logic [2:0]  an;
    logic [7:0]  seg;

    int checks   = 0;
    int failures = 0;

    seg_scan_3 #(.SCAN_DIV(16'd4)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .bcd  (bcd),
        .done (done),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
            4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
            8: return 8'h80; 9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // slot 0 = ones, 1 = tens, 2 = hundreds
    function automatic logic [7:0] exp_seg(input int v, input int slot);
        int h, t, o;
        h = v / 100; t = (v / 10) % 10; o = v % 10;
`ifdef SEG_SCAN_LZB_EN
        if (slot == 2 && h == 0) return 8'hFF;
        if (slot == 1 && h == 0 && t == 0) return 8'hFF;
`endif
        return (slot == 0) ? pat(o) : (slot == 1) ? pat(t) : pat(h);
    endfunction

    // Counts rising edges until done is seen at a falling edge.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
    endtask

    // Watches one full scan round and checks every slot's pattern.
    task automatic check_display(input int v);
        int seen0, seen1, seen2, slot;
        seen0 = 0; seen1 = 0; seen2 = 0;
        for (int k = 0; k < 3 * DIV + 1; k++) begin
            @(negedge clk);
            slot = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : (an == 3'b011) ? 2 : 3;
            chk("an_legal", (slot < 3), 1'b1);
            if (slot == 0) seen0++;
            if (slot == 1) seen1++;
            if (slot == 2) seen2++;
            if (slot < 3) chk($sformatf("seg_v%0d_s%0d", v, slot), seg, exp_seg(v, slot));
        end
        chk("slots_all_seen", (seen0 > 0) && (seen1 > 0) && (seen2 > 0), 1'b1);
    endtask

    task automatic convert(input int v);
        int n;
        in = 8'(v);
        wait_done(n);
        chk($sformatf("lat_v%0d", v), n, 10);
        chk($sformatf("bcd_v%0d", v), bcd, to_bcd(v));
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int n, v, cur, pulses, len;
        int wvals[5];
        logic [11:0] got[$];
        logic [2:0]  hist[$];

        // Reset held for 3 cycles.
        rst = 1'b0; in = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 3'b111);
        chk("rst_bcd", bcd, 12'h000);
        chk("rst_done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_an", an, 3'b110);
        chk("first_seg", seg, 8'hC0);

        // Single conversion, then maximum value.
        convert(13);
        check_display(13);
        convert(255);
        check_display(255);

        // Wrap sequence: each value held 12 cycles.
        wvals = '{10, 11, 12, 13, 10};
        pulses = 0;
        foreach (wvals[i]) begin
            in = 8'(wvals[i]);
            repeat (12) begin
                @(negedge clk);
                if (done) begin pulses++; got.push_back(bcd); end
            end
        end
        chk("wrap_pulses", pulses, 5);
        foreach (wvals[i])
            if (i < got.size()) chk($sformatf("wrap_bcd%0d", i), got[i], to_bcd(wvals[i]));

        // Mid-conversion change from a fresh reset.
        rst = 1'b0; in = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in = 8'd10;
        repeat (3) @(posedge clk);
        #1 in = 8'd11;
        wait_done(n);
        chk("mid_bcd1", bcd, 12'h010);
        wait_done(n);
        chk("mid_gap", n, 10);
        chk("mid_bcd2", bcd, 12'h011);

        // Reset mid-SHIFT: asynchronous clear, no done, restart after.
        @(negedge clk);
        in = 8'd200;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_seg", seg, 8'hFF);
        chk("arst_an", an, 3'b111);
        chk("arst_bcd", bcd, 12'h000);
        chk("arst_done", done, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_hold_done", done, 1'b0);
        end
        rst = 1'b1;
        wait_done(n);
        chk("arst_restart_lat", n, 10);
        chk("arst_restart_bcd", bcd, 12'h200);

        // Scan period: every complete run of an lasts DIV cycles.
        for (int k = 0; k < 10 * DIV; k++) begin
            @(negedge clk);
            hist.push_back(an);
        end
        len = 1;
        for (int k = 1; k < hist.size(); k++) begin
            chk("scan_an_legal", (hist[k] == 3'b110 || hist[k] == 3'b101 || hist[k] == 3'b011), 1'b1);
            if (hist[k] != hist[k-1]) begin
                chk("scan_order", hist[k],
                    (hist[k-1] == 3'b110) ? 3'b101 : (hist[k-1] == 3'b101) ? 3'b011 : 3'b110);
                if (len != k) chk("scan_run_len", len, DIV);
                len = 1;
            end else begin
                len++;
            end
        end

        // Randomized values against the arithmetic model.
        cur = 200;
        for (int r = 0; r < 6; r++) begin
            v = $urandom_range(0, 255);
            if (v == cur) v = (v + 1) % 256;
            convert(v);
            check_display(v);
            cur = v;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_3.md
# seg_scan_3

Downstream display stage for the bounded up-counter: consumes its 8-bit `out` value, converts it to three BCD digits with a sequential double-dabble engine, and drives a time-multiplexed 3-digit common-anode seven-segment display. The converter re-runs whenever the input value changes. The scan runs continuously, independent of conversion.

## Interface
- `SCAN_DIV`, default 16'd50000: clock cycles each digit stays selected. Legal range is 1..65535.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in`  in  8  binary value from the counter; unsigned, 0..255.
- `bcd`  out  12  last converted value as {hundreds, tens, ones}, 4 bits each.
- `done`  out  1  one-cycle pulse when `bcd` updates.
- `an`  out  3  digit enables, active-low, one-hot. `an[0]` is ones, `an[2]` is hundreds.
- `seg`  out  8  segments, active-low, ordered {dp, g, f, e, d, c, b, a}. `dp` is always 1.

## Operation
- Reset values:
  - outputs: `bcd`=12'h000, `done`=0, `an`=3'b111, `seg`=8'hFF.
  - internal: `last`=8'd0, FSM=IDLE, scan prescaler=0, digit index=0.
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: if `in`≠`last`, capture `in` into the shift register and into `last`, clear the BCD scratch, clear the bit counter, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shreg} left by 1. After the 8th shift, go to DONE.
  - DONE: copy scratch to `bcd`, assert `done` for exactly one cycle, return to IDLE.
- `in` changes during SHIFT or DONE are ignored. Back in IDLE, the value present at that time is compared against `last`, so only the newest value is converted; intermediate values are dropped.
- Arithmetic: the scratch register is 12 bits and the bit counter is 3 bits. Worst case 8'd255 gives 12'h255 with no overflow.
- Scan logic:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On each wrap, the digit index advances 0→1→2→0. Index 3 never occurs.
- Output register: each cycle, `an` and `seg` are registered from the current index and `bcd`.
  - Index 0 drives `an`=3'b110, index 1 drives 3'b101, index 2 drives 3'b011.
- Digit patterns (`seg`): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Digit codes above 9 cannot arise. If one does, drive `seg`=8'hFF.

## Timing
- Let edge 0 be the IDLE edge that captures a changed `in`.
  - Edges 1..8 are the shifts.
  - Edge 9 updates `bcd` and raises `done`.
  - `done` falls at edge 10.
  - The earliest next capture is edge 10. The conversion period is 10 cycles.
- `seg`/`an` reflect a new `bcd` no later than the first output-register edge after edge 9.
- The first output-register edge after `rst` deasserts drives `an`=3'b110 with the ones digit.
- Reset mid-conversion: everything returns to reset values immediately and any partial result is discarded. If `in`≠0 after release, a conversion starts on the first edge.
- With SCAN_DIV=1, the digit advances every cycle.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - The hundreds digit drives `seg`=8'hFF when hundreds=0.
  - The tens digit drives 8'hFF when hundreds=0 and tens=0.
  - The ones digit is never blanked.
  - `an` still scans normally.
- `SEG_SCAN_LZB_EN` undefined: all three digits always show their numeral, so 8'd7 displays as "007".
- `bcd` and `done` are identical in both builds.

## Structure
- Shared package `seg_pkg` holds:
  - FSM state encodings (IDLE, SHIFT, DONE).
  - The ten digit-to-segment constants and `SEG_BLANK`=8'hFF.
  - The `an` one-hot constants.
- Sub-module `bin2bcd_seq` contains the IDLE/SHIFT/DONE converter, with ports `clk`, `rst`, `in`, `bcd`, `done`.
- `seg_scan_3` contains the prescaler, digit index, blanking and output registers.

## Test plan
- Reset checks:
  - Hold `rst`=0 for 3 cycles → `seg`=8'hFF, `an`=3'b111, `bcd`=0, `done`=0.
  - Assert `rst`=0 mid-SHIFT → the same values asynchronously, and no `done` pulse.
- Single conversion: `in`=8'd13 after reset → `done` pulse 9 cycles after capture, `bcd`=12'h013. With SCAN_DIV=4, the ones slot shows B0, tens F9, hundreds C0 (no macro) or FF (with macro).
- Maximum value: `in`=8'd255 → `bcd`=12'h255. Hundreds slot shows `seg`=A4 with `an`=3'b011.
- Wrap sequence: drive `in` through 10,11,12,13,10, holding each for 12 cycles → exactly 5 `done` pulses, with `bcd` following 010,011,012,013,010.
- Mid-conversion change: `in`=10, then `in`=11 three cycles later → first `done` with 12'h010, second with 12'h011, 10 cycles apart.
- Scan period: SCAN_DIV=4, `in` constant → `an` cycles 110,101,011, each held exactly 4 cycles. No other `an` values appear.
